// File: rtl/i2c_qsfp_responder.sv
// ---------------------------------------------------------------------------
// i2c_qsfp_responder
// I2C target that emulates a 256-byte QSFP-style memory map. The bus
// controller writes a byte pointer, then writes or reads sequential bytes;
// the pointer wraps at 8'hFF and persists between transactions. A host-side
// preload port writes the same memory (and wins on a same-address
// collision), and an independent monitor port reads it back.
//
// Ports
//   clk, rst_n        system clock (rising edge), async active-low reset
//   scl, sda          raw I2C bus levels, asynchronous to clk
//   sda_drive_low     1 = pull SDA low (open drain), 0 = release
//   load_en/addr/data host preload write, one byte per cycle
//   mon_addr/mon_data host monitor read, one-cycle registered latency
//   busy              high from an accepted START until STOP or address miss
//   byte_written      one-cycle pulse per bus byte committed to memory
// ---------------------------------------------------------------------------
module i2c_qsfp_responder #(
    parameter logic [6:0]  DEVICE_ADDR = 7'h50,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda,
    output logic       sda_drive_low,
    input  logic       load_en,
    input  logic [7:0] load_addr,
    input  logic [7:0] load_data,
    input  logic [7:0] mon_addr,
    output logic [7:0] mon_data,
    output logic       busy,
    output logic       byte_written
);

    localparam int unsigned      CNT_W   = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;

    logic             scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic             scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic [CNT_W-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic             scl_fp_q, sda_fp_q;

    logic [3:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;
    logic       drive_q, drive_d;
    logic       busy_q, busy_d;
    logic       bw_q, bw_d;
    logic [7:0] mon_q, mon_d;
    logic       bus_we;

    logic [7:0] mem [256];
    logic [7:0] mem_rd;

    logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;

    // A raw level is accepted only after it has differed from the current
    // filtered level for FILTER_LEN consecutive cycles; any bounce restarts
    // the count, so short glitches never reach the protocol logic.
    always_comb begin
        scl_f_d   = scl_f_q;
        scl_cnt_d = '0;
        sda_f_d   = sda_f_q;
        sda_cnt_d = '0;
        if (scl_s2_q != scl_f_q) begin
            if (scl_cnt_q == CNT_MAX) scl_f_d = scl_s2_q;
            else                      scl_cnt_d = scl_cnt_q + 1'b1;
        end
        if (sda_s2_q != sda_f_q) begin
            if (sda_cnt_q == CNT_MAX) sda_f_d = sda_s2_q;
            else                      sda_cnt_d = sda_cnt_q + 1'b1;
        end
    end

    assign scl_rise  =  scl_f_q & ~scl_fp_q;
    assign scl_fall  = ~scl_f_q &  scl_fp_q;
    assign sda_rise  =  sda_f_q & ~sda_fp_q;
    assign sda_fall  = ~sda_f_q &  sda_fp_q;
    assign start_det =  sda_fall & scl_f_q;
    assign stop_det  =  sda_rise & scl_f_q;

    assign mem_rd = mem[ptr_q];

    // Bits are sampled on SCL rise; every change of sda_drive_low is made on
    // an SCL fall so the line is stable before the controller's next rise.
    // A byte is complete when the fall after the eighth rise arrives.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        drive_d   = drive_q;
        busy_d    = busy_q;
        bw_d      = 1'b0;
        bus_we    = 1'b0;
        mon_d     = mem[mon_addr];

        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            drive_d   = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            drive_d   = 1'b0;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_f_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        drive_d   = 1'b1;
                        if (state_q == ST_ADDR) begin
                            if (shift_q[7:1] == DEVICE_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = shift_q[0];
                            end else begin
                                state_d = ST_IDLE;
                                drive_d = 1'b0;
                                busy_d  = 1'b0;
                            end
                        end else if (state_q == ST_PTR) begin
                            state_d = ST_PTR_ACK;
                            ptr_d   = shift_q;
                        end else begin
                            // Commit happens at the fall that opens the ACK slot.
                            state_d = ST_WDATA_ACK;
                            bus_we  = 1'b1;
                            bw_d    = 1'b1;
                            ptr_d   = ptr_q + 8'd1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d = ST_RDATA;
                            shift_d = mem_rd;
                            drive_d = ~mem_rd[7];
                        end else begin
                            state_d = ST_PTR;
                            drive_d = 1'b0;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d   = ST_WDATA;
                        bit_cnt_d = '0;
                        drive_d   = 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = ST_RDATA_ACK;
                            bit_cnt_d = '0;
                            drive_d   = 1'b0;
                            ptr_d     = ptr_q + 8'd1;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            drive_d = ~shift_q[6];
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        ack_d = ~sda_f_q;
                    end else if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (ack_q) begin
                            state_d = ST_RDATA;
                            shift_d = mem_rd;
                            drive_d = ~mem_rd[7];
                        end else begin
                            state_d = ST_IDLE;
                            drive_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Synchronizer and filter flops reset to 1 so the bus looks idle and no
    // spurious edge is seen when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q  <= 1'b1;
            scl_s2_q  <= 1'b1;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_fp_q  <= 1'b1;
            sda_fp_q  <= 1'b1;
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b0;
            drive_q   <= 1'b0;
            busy_q    <= 1'b0;
            bw_q      <= 1'b0;
            mon_q     <= '0;
        end else begin
            scl_s1_q  <= scl;
            scl_s2_q  <= scl_s1_q;
            sda_s1_q  <= sda;
            sda_s2_q  <= sda_s1_q;
            scl_f_q   <= scl_f_d;
            sda_f_q   <= sda_f_d;
            scl_fp_q  <= scl_f_q;
            sda_fp_q  <= sda_f_q;
            scl_cnt_q <= scl_cnt_d;
            sda_cnt_q <= sda_cnt_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            drive_q   <= drive_d;
            busy_q    <= busy_d;
            bw_q      <= bw_d;
            mon_q     <= mon_d;
        end
    end

    // Memory is deliberately not reset. The host write is issued last so it
    // takes precedence when both writers target the same byte.
    always_ff @(posedge clk) begin
        if (bus_we)  mem[ptr_q]     <= shift_q;
        if (load_en) mem[load_addr] <= load_data;
    end

    assign sda_drive_low = drive_q;
    assign busy          = busy_q;
    assign byte_written  = bw_q;
    assign mon_data      = mon_q;

endmodule

// File: tb/tb_i2c_qsfp_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_qsfp_responder
// Directed bench for i2c_qsfp_responder: a bit-banged I2C controller drives
// scl/sda (open drain, wired-AND with the DUT's pull-down), the host ports
// preload and inspect memory, and each observation is compared against a
// hand-computed value.
// ---------------------------------------------------------------------------
module tb_i2c_qsfp_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_ctrl;
    logic       sda_drive_low;
    logic       load_en;
    logic [7:0] load_addr;
    logic [7:0] load_data;
    logic [7:0] mon_addr;
    logic [7:0] mon_data;
    logic       busy;
    logic       byte_written;
    logic       sda_bus;

    int checks    = 0;
    int errors    = 0;
    int bw_count  = 0;

    assign sda_bus = sda_ctrl & ~sda_drive_low;

    i2c_qsfp_responder #(.DEVICE_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scl          (scl),
        .sda          (sda_bus),
        .sda_drive_low(sda_drive_low),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .mon_addr     (mon_addr),
        .mon_data     (mon_data),
        .busy         (busy),
        .byte_written (byte_written)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_written === 1'b1) bw_count++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic scl_v, input logic sda_v, input int cycles);
        scl      = scl_v;
        sda_ctrl = sda_v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic readMon(input logic [7:0] a, output logic [7:0] d);
        mon_addr = a;
        @(negedge clk);
        d = mon_data;
    endtask

    task automatic i2cStart();
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);
    endtask

    task automatic i2cRestart();
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 10);
    endtask

    task automatic i2cStop();
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 10);
    endtask

    task automatic writeBit(input logic b);
        applyStimulus(1'b0, b, 10);
        applyStimulus(1'b1, b, 20);
        applyStimulus(1'b0, b, 10);
    endtask

    task automatic ackSlot(input logic exp_ack, input string tag);
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 10);
        checkOutput(tag, {7'd0, ~sda_bus}, {7'd0, exp_ack});
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 10);
    endtask

    task automatic writeByte(input logic [7:0] d, input logic exp_ack, input string tag);
        for (int i = 7; i >= 0; i--) writeBit(d[i]);
        ackSlot(exp_ack, tag);
    endtask

    task automatic readByte(input logic send_ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1, 10);
            applyStimulus(1'b1, 1'b1, 10);
            d[i] = sda_bus;
            applyStimulus(1'b1, 1'b1, 10);
        end
        applyStimulus(1'b0, ~send_ack, 10);
        applyStimulus(1'b1, ~send_ack, 20);
        applyStimulus(1'b0, ~send_ack, 10);
        sda_ctrl = 1'b1;
    endtask

    logic [7:0] rd;

    initial begin
        rst_n     = 1'b0;
        scl       = 1'b1;
        sda_ctrl  = 1'b1;
        load_en   = 1'b0;
        load_addr = 8'h00;
        load_data = 8'h00;
        mon_addr  = 8'h00;
        repeat (3) @(negedge clk);

        checkOutput("reset_sda_drive_low", {7'd0, sda_drive_low}, 8'h00);
        checkOutput("reset_busy",          {7'd0, busy},          8'h00);
        checkOutput("reset_byte_written",  {7'd0, byte_written},  8'h00);
        checkOutput("reset_mon_data",      mon_data,              8'h00);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        preload(8'h14, 8'hA5);
        preload(8'h15, 8'h3C);
        preload(8'h01, 8'h5A);
        preload(8'h21, 8'hC0);

        // Pointer write, repeated START, two-byte sequential read
        i2cStart();
        checkOutput("busy_after_start", {7'd0, busy}, 8'h01);
        writeByte(8'hA0, 1'b1, "rd_addr_w_ack");
        writeByte(8'h14, 1'b1, "rd_ptr_ack");
        i2cRestart();
        writeByte(8'hA1, 1'b1, "rd_addr_r_ack");
        readByte(1'b1, rd);
        checkOutput("rd_byte0", rd, 8'hA5);
        readByte(1'b0, rd);
        checkOutput("rd_byte1", rd, 8'h3C);
        i2cStop();
        checkOutput("rd_sda_released", {7'd0, sda_drive_low}, 8'h00);
        checkOutput("rd_busy_after_stop", {7'd0, busy}, 8'h00);

        // Three-byte write crossing the 0xFF -> 0x00 wrap
        i2cStart();
        writeByte(8'hA0, 1'b1, "wr_addr_ack");
        writeByte(8'hFE, 1'b1, "wr_ptr_ack");
        writeByte(8'h11, 1'b1, "wr_d0_ack");
        writeByte(8'h22, 1'b1, "wr_d1_ack");
        writeByte(8'h33, 1'b1, "wr_d2_ack");
        i2cStop();
        readMon(8'hFE, rd);
        checkOutput("mem_FE", rd, 8'h11);
        readMon(8'hFF, rd);
        checkOutput("mem_FF", rd, 8'h22);
        readMon(8'h00, rd);
        checkOutput("mem_00", rd, 8'h33);
        checkOutput("byte_written_pulses", 8'(bw_count), 8'd3);

        // Pointer left at 0x01 by the wrapped write
        i2cStart();
        writeByte(8'hA1, 1'b1, "ptr01_addr_ack");
        readByte(1'b0, rd);
        checkOutput("ptr01_data", rd, 8'h5A);
        i2cStop();

        // Wrong device address: no ACK, busy drops, memory untouched
        i2cStart();
        writeByte(8'hA2, 1'b0, "miss_no_ack");
        checkOutput("miss_busy", {7'd0, busy}, 8'h00);
        i2cStop();
        readMon(8'hFE, rd);
        checkOutput("miss_mem_FE", rd, 8'h11);
        checkOutput("miss_no_write", 8'(bw_count), 8'd3);

        // One-cycle SDA glitch while SCL high must not look like START
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 20);
        checkOutput("glitch_busy", {7'd0, busy}, 8'h00);

        // Host preload colliding with a bus write to 0x20: host data wins.
        // The filtered SCL fall reaches the FSM on the sixth rising edge
        // after SCL is driven low, which is when load_en is presented.
        i2cStart();
        writeByte(8'hA0, 1'b1, "coll_addr_ack");
        writeByte(8'h20, 1'b1, "coll_ptr_ack");
        for (int i = 7; i >= 1; i--) writeBit(1'(8'h55 >> i));
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 20);
        scl = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 8'h20;
        load_data = 8'h77;
        @(negedge clk);
        load_en   = 1'b0;
        checkOutput("coll_byte_written", {7'd0, byte_written}, 8'h01);
        applyStimulus(1'b0, 1'b1, 4);
        applyStimulus(1'b1, 1'b1, 10);
        checkOutput("coll_data_ack", {7'd0, ~sda_bus}, 8'h01);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 10);
        i2cStop();
        readMon(8'h00, rd);
        readMon(8'h20, rd);
        checkOutput("coll_mem_20", rd, 8'h77);

        // Reset during the third bit of a read of 0xC0 (bit is 0, so driven)
        i2cStart();
        writeByte(8'hA1, 1'b1, "rst_addr_ack");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 10);
            applyStimulus(1'b1, 1'b1, 20);
        end
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 10);
        checkOutput("rst_bit2_driven", {7'd0, sda_bus}, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_sda_released", {7'd0, sda_drive_low}, 8'h00);
        checkOutput("rst_busy", {7'd0, busy}, 8'h00);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 5);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 20);
        checkOutput("rst_idle_busy", {7'd0, busy}, 8'h00);
        i2cStart();
        writeByte(8'hA1, 1'b1, "rst_reread_ack");
        readByte(1'b0, rd);
        checkOutput("rst_ptr_zero_data", rd, 8'h33);
        i2cStop();
        checkOutput("final_sda_released", {7'd0, sda_drive_low}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
